// File: rtl/fifo_ptr_pkg.sv
// rtl/fifo_ptr_pkg.sv - wrap-bit pointer helpers shared by FIFO reader and writer
package fifo_ptr_pkg;

    // Pointers are {wrap, idx} with the wrap bit at position aw; arguments are
    // zero-extended to 32 bits so any DEPTH (not only powers of two) works.
    function automatic logic [31:0] ptr_inc(input logic [31:0] ptr,
                                            input logic [31:0] depth,
                                            input logic [31:0] aw);
        logic [31:0] wrap_bit;
        logic [31:0] idx;
        wrap_bit = 32'd1 << aw;
        idx      = ptr & (wrap_bit - 32'd1);
        if (idx == depth - 32'd1) begin
            return (ptr & wrap_bit) ^ wrap_bit;
        end
        return (ptr & wrap_bit) | (idx + 32'd1);
    endfunction

    function automatic logic [31:0] ptr_count(input logic [31:0] wr_ptr,
                                              input logic [31:0] rd_ptr,
                                              input logic [31:0] depth,
                                              input logic [31:0] aw);
        logic [31:0] wrap_bit;
        logic [31:0] widx;
        logic [31:0] ridx;
        wrap_bit = 32'd1 << aw;
        widx     = wr_ptr & (wrap_bit - 32'd1);
        ridx     = rd_ptr & (wrap_bit - 32'd1);
        if (((wr_ptr ^ rd_ptr) & wrap_bit) == 32'd0) begin
            return widx - ridx;
        end
        return depth - ridx + widx;
    endfunction

endpackage

// File: rtl/fifo_out_skid.sv
// rtl/fifo_out_skid.sv - two-entry in-order output buffer
module fifo_out_skid #(
    parameter int DW = 8
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic          i_push,
    input  logic          i_pop,
    input  logic [DW-1:0] i_data,
    output logic [DW-1:0] o_data,
    output logic [1:0]    o_count
);
    logic [DW-1:0] head_q, head_d;
    logic [DW-1:0] tail_q, tail_d;
    logic [1:0]    cnt_q, cnt_d;
    logic          do_pop;

    always_comb begin
        head_d = head_q;
        tail_d = tail_q;
        cnt_d  = cnt_q;
        do_pop = i_pop && (cnt_q != 2'd0);
        case ({i_push, do_pop})
            2'b10: begin
                if (cnt_q == 2'd0) begin
                    head_d = i_data;
                    cnt_d  = 2'd1;
                end else if (cnt_q == 2'd1) begin
                    tail_d = i_data;
                    cnt_d  = 2'd2;
                end
            end
            2'b01: begin
                head_d = tail_q;
                cnt_d  = cnt_q - 2'd1;
            end
            2'b11: begin
                // Count stays put; the incoming word lands behind whatever remains.
                if (cnt_q == 2'd1) begin
                    head_d = i_data;
                end else begin
                    head_d = tail_q;
                    tail_d = i_data;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            head_q <= '0;
            tail_q <= '0;
            cnt_q  <= 2'd0;
        end else begin
            head_q <= head_d;
            tail_q <= tail_d;
            cnt_q  <= cnt_d;
        end
    end

    assign o_data  = head_q;
    assign o_count = cnt_q;

endmodule

// File: rtl/fifo_read_ctrl.sv
// rtl/fifo_read_ctrl.sv - FIFO read side: pointer, storage fetch and output skid buffer
module fifo_read_ctrl
    import fifo_ptr_pkg::*;
#(
    parameter int DEPTH = 10,
    parameter int DW    = 8,
    parameter int AW    = $clog2(DEPTH),
    parameter int PW    = AW + 1
) (
    input  logic          i_clk,
    input  logic          i_rst,
    input  logic [PW-1:0] i_wr_ptr,
    input  logic [DW-1:0] i_mem_rdata,
    input  logic          i_rd_ready,
    output logic          o_mem_rd_en,
    output logic [AW-1:0] o_mem_rd_addr,
    output logic          o_rd_valid,
    output logic [DW-1:0] o_rd_data,
    output logic [PW-1:0] o_rd_ptr,
    output logic [AW:0]   o_count,
    output logic          o_empty
);
    localparam int CW = AW + 1;

    logic [PW-1:0] rd_ptr_q, rd_ptr_d;
    logic          inflight_q, inflight_d;
    logic [1:0]    buf_cnt;
    logic          pop;
    logic [2:0]    occupancy;

    always_comb begin
        o_empty   = (i_wr_ptr == rd_ptr_q);
        o_count   = CW'(ptr_count(32'(i_wr_ptr), 32'(rd_ptr_q), 32'(DEPTH), 32'(AW)));
        o_rd_valid = (buf_cnt != 2'd0);
        pop       = o_rd_valid && i_rd_ready;
        // Entries held or already on their way once this edge's pop is taken.
        occupancy = {1'b0, buf_cnt} + {2'b00, inflight_q} - {2'b00, pop};
        o_mem_rd_en = !o_empty && (occupancy < 3'd2);
        rd_ptr_d  = o_mem_rd_en ? PW'(ptr_inc(32'(rd_ptr_q), 32'(DEPTH), 32'(AW))) : rd_ptr_q;
        inflight_d = o_mem_rd_en;
        o_mem_rd_addr = rd_ptr_q[AW-1:0];
        o_rd_ptr  = rd_ptr_q;
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr_q   <= '0;
            inflight_q <= 1'b0;
        end else begin
            rd_ptr_q   <= rd_ptr_d;
            inflight_q <= inflight_d;
        end
    end

    fifo_out_skid #(
        .DW(DW)
    ) u_skid (
        .i_clk   (i_clk),
        .i_rst   (i_rst),
        .i_push  (inflight_q),
        .i_pop   (pop),
        .i_data  (i_mem_rdata),
        .o_data  (o_rd_data),
        .o_count (buf_cnt)
    );

endmodule

// File: tb/tb_fifo_read_ctrl.sv
// tb/tb_fifo_read_ctrl.sv - self-checking bench for fifo_read_ctrl
module tb_fifo_read_ctrl;
    localparam int DEPTH = 10;
    localparam int DW    = 8;
    localparam int AW    = 4;
    localparam int PW    = 5;

    logic          i_clk;
    logic          i_rst;
    logic [PW-1:0] i_wr_ptr;
    logic [DW-1:0] i_mem_rdata;
    logic          i_rd_ready;
    logic          o_mem_rd_en;
    logic [AW-1:0] o_mem_rd_addr;
    logic          o_rd_valid;
    logic [DW-1:0] o_rd_data;
    logic [PW-1:0] o_rd_ptr;
    logic [AW:0]   o_count;
    logic          o_empty;

    fifo_read_ctrl #(.DEPTH(DEPTH), .DW(DW)) dut (
        .i_clk         (i_clk),
        .i_rst         (i_rst),
        .i_wr_ptr      (i_wr_ptr),
        .i_mem_rdata   (i_mem_rdata),
        .i_rd_ready    (i_rd_ready),
        .o_mem_rd_en   (o_mem_rd_en),
        .o_mem_rd_addr (o_mem_rd_addr),
        .o_rd_valid    (o_rd_valid),
        .o_rd_data     (o_rd_data),
        .o_rd_ptr      (o_rd_ptr),
        .o_count       (o_count),
        .o_empty       (o_empty)
    );

    initial i_clk = 1'b0;
    always #5 i_clk = ~i_clk;

    logic [DW-1:0] mem [0:15];
    always @(posedge i_clk) begin
        if (o_mem_rd_en) i_mem_rdata <= mem[o_mem_rd_addr];
    end

    int n_chk;
    int n_fail;
    int written;
    int fetched;
    int popped;
    logic [DW-1:0] exp_q [$];

    typedef struct {
        logic [PW-1:0] wr_ptr;
        int            exp_count;
        logic          exp_empty;
        logic          exp_en;
    } vec_t;
    vec_t vecs [6];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    function automatic logic [PW-1:0] ptr_of(input int n);
        logic [PW-1:0] p;
        p[PW-1]   = ((n / DEPTH) % 2) != 0;
        p[AW-1:0] = AW'(n % DEPTH);
        return p;
    endfunction

    task automatic push_entry(input logic [DW-1:0] d);
        mem[written % DEPTH] = d;
        exp_q.push_back(d);
        written++;
        i_wr_ptr = ptr_of(written);
    endtask

    task automatic model_clear();
        written = 0;
        fetched = 0;
        popped  = 0;
        exp_q.delete();
        i_wr_ptr = '0;
    endtask

    // Model: pointer and counts follow from how many entries were written and fetched.
    task automatic cycle();
        logic [DW-1:0] e;
        #1;
        check("rd_ptr", 32'(o_rd_ptr), 32'(ptr_of(fetched)));
        check("count", 32'(o_count), 32'(written - fetched));
        check("empty", 32'(o_empty), 32'(written == fetched));
        if (o_rd_valid && i_rd_ready) begin
            if (exp_q.size() == 0) begin
                check("stale_pop", 32'd1, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("rd_data", 32'(o_rd_data), 32'(e));
            end
            popped++;
        end
        if (o_mem_rd_en) fetched++;
        check("lookahead_le2", 32'((fetched - popped) <= 2), 32'd1);
        @(posedge i_clk);
        #1;
    endtask

    task automatic run_until_popped(input int target, input int budget, input string name);
        int n;
        n = 0;
        while (popped < target && n < budget) begin
            cycle();
            n++;
        end
        check(name, 32'(popped), 32'(target));
    endtask

    task automatic do_reset();
        i_rst = 1'b1;
        i_rd_ready = 1'b0;
        model_clear();
        @(posedge i_clk);
        #1;
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
    endtask

    initial begin
        #5_000_000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int first_pop;
        int last_pop;
        int k;
        logic [DW-1:0] held;
        n_chk = 0;
        n_fail = 0;
        for (int i = 0; i < 16; i++) mem[i] = '0;
        i_rd_ready = 1'b0;

        // Reset state
        do_reset();
        #1;
        check("rst_valid", 32'(o_rd_valid), 32'd0);
        check("rst_data", 32'(o_rd_data), 32'd0);
        check("rst_ptr", 32'(o_rd_ptr), 32'd0);
        check("rst_empty", 32'(o_empty), 32'd1);
        check("rst_count", 32'(o_count), 32'd0);
        check("rst_en", 32'(o_mem_rd_en), 32'd0);

        // Combinational count/empty/enable with the read side held in reset
        vecs[0] = '{5'b0_0000, 0, 1'b1, 1'b0};
        vecs[1] = '{5'b0_0001, 1, 1'b0, 1'b1};
        vecs[2] = '{5'b0_1001, 9, 1'b0, 1'b1};
        vecs[3] = '{5'b1_0000, 10, 1'b0, 1'b1};
        vecs[4] = '{5'b0_0101, 5, 1'b0, 1'b1};
        vecs[5] = '{5'b1_0000, 10, 1'b0, 1'b1};
        i_rst = 1'b1;
        for (int i = 0; i < 6; i++) begin
            i_wr_ptr = vecs[i].wr_ptr;
            #1;
            check("tbl_count", 32'(o_count), 32'(vecs[i].exp_count));
            check("tbl_empty", 32'(o_empty), 32'(vecs[i].exp_empty));
            check("tbl_en", 32'(o_mem_rd_en), 32'(vecs[i].exp_en));
        end

        // Single entry latency
        do_reset();
        i_rd_ready = 1'b1;
        push_entry(8'hA5);
        #1;
        check("single_en_c0", 32'(o_mem_rd_en), 32'd1);
        check("single_addr_c0", 32'(o_mem_rd_addr), 32'd0);
        check("single_valid_c0", 32'(o_rd_valid), 32'd0);
        cycle();
        check("single_valid_c1", 32'(o_rd_valid), 32'd0);
        cycle();
        check("single_valid_c2", 32'(o_rd_valid), 32'd1);
        check("single_data_c2", 32'(o_rd_data), 32'hA5);
        cycle();
        check("single_valid_c3", 32'(o_rd_valid), 32'd0);
        check("single_ptr_c3", 32'(o_rd_ptr), 32'd1);

        // Wrap and wrapped count
        do_reset();
        i_rd_ready = 1'b1;
        for (int i = 0; i < 7; i++) push_entry(DW'(8'h10 + i));
        run_until_popped(7, 40, "wrap_drain7");
        check("wrap_ptr7", 32'(o_rd_ptr), 32'b0_0111);
        for (int i = 0; i < 6; i++) push_entry(DW'(8'h20 + i));
        #1;
        check("wrap_count6", 32'(o_count), 32'd6);
        k = 0;
        while (o_rd_ptr != 5'b0_1001 && k < 20) begin
            cycle();
            k++;
        end
        check("wrap_reach9", 32'(o_rd_ptr), 32'b0_1001);
        check("wrap_en_at9", 32'(o_mem_rd_en), 32'd1);
        cycle();
        check("wrap_ptr_after", 32'(o_rd_ptr), 32'b1_0000);
        run_until_popped(13, 40, "wrap_drain13");

        // Back-pressure
        do_reset();
        i_rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_entry(DW'(i));
        #1;
        check("bp_count10", 32'(o_count), 32'd10);
        for (int i = 0; i < 6; i++) cycle();
        check("bp_ptr", 32'(o_rd_ptr), 32'd2);
        check("bp_count", 32'(o_count), 32'd8);
        check("bp_en", 32'(o_mem_rd_en), 32'd0);
        check("bp_valid", 32'(o_rd_valid), 32'd1);
        check("bp_data", 32'(o_rd_data), 32'd0);
        held = o_rd_data;
        for (int i = 0; i < 3; i++) begin
            cycle();
            check("bp_stable", 32'(o_rd_data), 32'(held));
        end
        i_rd_ready = 1'b1;
        first_pop = -1;
        last_pop = -1;
        for (int c = 0; c < 40 && popped < 10; c++) begin
            #1;
            if (o_rd_valid) begin
                if (first_pop < 0) first_pop = c;
                last_pop = c;
            end
            cycle();
        end
        check("bp_all10", 32'(popped), 32'd10);
        check("bp_no_gap", 32'(last_pop - first_pop), 32'd9);

        // Random ready, writer stalls when storage is full
        do_reset();
        k = 0;
        while (popped < 1000 && k < 20000) begin
            i_rd_ready = ($urandom_range(0, 3) != 0);
            if (written < 1000 && (written - fetched) < DEPTH && $urandom_range(0, 2) != 0)
                push_entry(DW'($urandom));
            cycle();
            k++;
        end
        check("rand_popped", 32'(popped), 32'd1000);
        check("rand_q_empty", 32'(exp_q.size()), 32'd0);

        // Reset while a read is in flight and another is being issued
        do_reset();
        i_rd_ready = 1'b0;
        for (int i = 0; i < 10; i++) push_entry(DW'(8'h50 + i));
        cycle();
        #1;
        check("mrst_en_before", 32'(o_mem_rd_en), 32'd1);
        i_rst = 1'b1;
        @(posedge i_clk);
        #1;
        model_clear();
        check("mrst_valid", 32'(o_rd_valid), 32'd0);
        check("mrst_ptr", 32'(o_rd_ptr), 32'd0);
        @(posedge i_clk);
        #1;
        i_rst = 1'b0;
        i_rd_ready = 1'b1;
        for (int i = 0; i < 4; i++) cycle();
        check("mrst_no_stale", 32'(popped), 32'd0);
        for (int i = 0; i < 3; i++) push_entry(DW'(8'hC0 + i));
        run_until_popped(3, 20, "mrst_fresh3");

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
